waste_bin_counter: RTL and testbench
====================================

Name: waste_bin_counter

Overview:
- Parametrised, multi-channel successor to the single non-recyclable item counter.
- Keeps one item counter per waste category and flags a bin as full at a programmable limit.
- Supports operator bin-empty requests, saturate or wrap mode, a global accepted-item total, and sticky error flags.
- Sits between the sorting classifier, which supplies item pulses, and the timer/control level, which consumes the full flags and the total.

Parameters:
- N_CH, 2, number of waste channels (1..8).
- WIDTH, 4, bits per channel count.
- LIMIT, 9, count at which a bin is full (1..2^WIDTH-1).
- WRAP, 0, 0 = saturate at LIMIT; 1 = wrap LIMIT -> 0.
- TOT_W, 8, width of the global total counter.
- EMPTY_DELAY, 4, auto-empty delay in cycles (1..255). Used only with the optional feature.

Ports:
- clock, input, 1, system clock, rising edge.
- clear, input, 1, synchronous active-high reset.
- item_valid, input, 1, one item presented this cycle.
- item_ch, input, 3, channel index of the presented item.
- empty_req, input, N_CH, per-channel bin-empty request, level sampled each edge.
- count, output, N_CH*WIDTH, channel k count at bits [k*WIDTH +: WIDTH].
- full, output, N_CH, registered per-channel full flag.
- wrap_pulse, output, N_CH, one-cycle pulse when a channel wraps (WRAP=1 only).
- total, output, TOT_W, accepted items since clear, saturating.
- drop_err, output, 1, sticky: an item was dropped on a full bin (WRAP=0).
- bad_ch_err, output, 1, sticky: item_valid was seen with item_ch >= N_CH.

Behaviour:
- Reset: clear is synchronous and active-high; clock is the only clock. While clear=1 at a rising edge, every output goes to 0: count, full, wrap_pulse, total, drop_err, bad_ch_err, and the auto-empty timers. clear has priority over all other inputs. Asserting clear mid-count aborts the count; nothing is held.
- Timing: all outputs are registered. An item sampled at edge n is visible on count/total after edge n, i.e. one cycle of latency. No combinational input-to-output paths.
- Per-channel state machine, states COUNTING and FULL:
  - COUNTING: an accepted item increments count. When the increment makes count == LIMIT: with WRAP=0 go to FULL and set full on the same edge; with WRAP=1 stay in COUNTING, hold count at LIMIT, full=1 for that cycle only.
  - WRAP=1: the next item after count == LIMIT sets count to 0, pulses wrap_pulse for one cycle, and clears full.
  - FULL (WRAP=0 only): items for this channel are dropped and set drop_err. Count holds at LIMIT. Not counted in total.
- empty_req[k]=1 at an edge sets count[k]=0, full[k]=0 and the state to COUNTING.
- Simultaneous empty_req[k] and an item for channel k: empty wins and the item counts into the fresh bin, so count[k]=1. The item is accepted, total increments, no drop_err.
- Only one item per cycle. Other channels are unaffected by an item or empty on channel k.
- item_ch >= N_CH with item_valid=1: item ignored, bad_ch_err set, total unchanged.
- total increments by 1 per accepted item and saturates at 2^TOT_W-1 (no wrap). total is not reduced by empty_req.
- Sticky errors clear only on clear.
- Count arithmetic is unsigned WIDTH-bit. The counter can never exceed LIMIT.

Optional Feature:
- Macro: WASTE_BIN_AUTO_EMPTY_EN.
- Defined: each channel gains a timer loaded on the edge full[k] rises. After EMPTY_DELAY further edges in FULL, the channel empties automatically: count=0, full=0, state COUNTING, exactly as if empty_req[k]=1.
  - An explicit empty_req[k] during the wait empties immediately and cancels the timer.
  - With WRAP=1 the timer is unused.
- Undefined: no timers are instantiated. A full bin stays full until empty_req or clear.

Test Plan:
- Reset: clear=1 for 2 edges with item_valid=1, item_ch=0 -> count=0, full=0, total=0, errors 0. Release clear -> first item gives count[0]=1 one cycle later.
- Saturate (N_CH=2, WIDTH=4, LIMIT=9, WRAP=0): 11 items on ch0 -> count[0]=9, full[0] rises on the 9th-item edge, drop_err=1 after the 10th item, total=9, count[1]=0.
- Empty collision: ch1 at count 5, empty_req[1]=1 and item on ch1 in the same cycle -> count[1]=1, total increments by 1, drop_err unchanged.
- Wrap (WRAP=1, LIMIT=3): 5 items on ch0 -> count sequence 1,2,3,0,1; full[0]=1 for one cycle at 3; wrap_pulse[0]=1 for exactly one cycle on the 4th item.
- Bad channel and total saturation (N_CH=2, TOT_W=4): item_ch=5 -> bad_ch_err=1, counts unchanged. 20 valid items alternating ch0/ch1 with empties between -> total stops at 15.
- With WASTE_BIN_AUTO_EMPTY_EN, EMPTY_DELAY=4: fill ch0 to 9 -> full[0]=1 for exactly 4 edges, then count[0]=0 and full[0]=0. Repeat with empty_req[0] at edge 2 -> immediate empty, no later auto action.

Source files
------------

// File: rtl/waste_bin_counter.sv
// rtl/waste_bin_counter.sv - multi-channel waste bin item counter with full flags, total and sticky errors
// Optional auto-empty timers: define WASTE_BIN_AUTO_EMPTY_EN.
module waste_bin_counter #(
    parameter int N_CH        = 2,
    parameter int WIDTH       = 4,
    parameter int LIMIT       = 9,
    parameter int WRAP        = 0,
    parameter int TOT_W       = 8,
    parameter int EMPTY_DELAY = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    item_valid,
    input  logic [2:0]              item_ch,
    input  logic [N_CH-1:0]         empty_req,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         full,
    output logic [N_CH-1:0]         wrap_pulse,
    output logic [TOT_W-1:0]        total,
    output logic                    drop_err,
    output logic                    bad_ch_err
);

    typedef enum logic {S_COUNTING, S_FULL} state_t;

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    generate
        if (N_CH < 1 || N_CH > 8 || LIMIT < 1 || LIMIT > (2**WIDTH) - 1 ||
            EMPTY_DELAY < 1 || EMPTY_DELAY > 255) begin : g_bad_param
            $error("waste_bin_counter: parameter out of range");
        end
    endgenerate

    state_t           r_state     [N_CH];
    state_t           w_state_nxt [N_CH];
    state_t           w_base_st   [N_CH];
    logic [WIDTH-1:0] r_count     [N_CH];
    logic [WIDTH-1:0] w_count_nxt [N_CH];
    logic [WIDTH-1:0] w_base_cnt  [N_CH];
    logic [N_CH-1:0]  r_full;
    logic [N_CH-1:0]  w_full_nxt;
    logic [N_CH-1:0]  r_wrap;
    logic [N_CH-1:0]  w_wrap_nxt;
    logic [N_CH-1:0]  w_hit;
    logic [N_CH-1:0]  w_accept;
    logic [N_CH-1:0]  w_drop;
    logic [N_CH-1:0]  w_empty;
    logic [N_CH-1:0]  w_auto;
    logic [TOT_W-1:0] r_total;
    logic             r_drop_err;
    logic             r_bad_ch_err;
    logic             w_bad_ch;

    assign w_bad_ch = item_valid && ({1'b0, item_ch} >= 4'(N_CH));

    // Empty (explicit or automatic) is applied first; a same-cycle item then counts into the fresh bin.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_hit[k]       = item_valid && (item_ch == 3'(k));
            w_empty[k]     = empty_req[k] | w_auto[k];
            w_base_cnt[k]  = w_empty[k] ? '0 : r_count[k];
            w_base_st[k]   = w_empty[k] ? S_COUNTING : r_state[k];
            w_count_nxt[k] = w_base_cnt[k];
            w_state_nxt[k] = w_base_st[k];
            w_full_nxt[k]  = (WRAP == 0) && (w_base_st[k] == S_FULL);
            w_wrap_nxt[k]  = 1'b0;
            w_accept[k]    = 1'b0;
            w_drop[k]      = 1'b0;
            if (w_hit[k]) begin
                if (w_base_st[k] == S_FULL) begin
                    w_drop[k] = 1'b1;
                end else begin
                    w_accept[k] = 1'b1;
                    if ((WRAP != 0) && (w_base_cnt[k] == LIM)) begin
                        w_count_nxt[k] = '0;
                        w_wrap_nxt[k]  = 1'b1;
                    end else begin
                        w_count_nxt[k] = w_base_cnt[k] + 1'b1;
                        if (w_base_cnt[k] + 1'b1 == LIM) begin
                            w_full_nxt[k] = 1'b1;
                            if (WRAP == 0) begin
                                w_state_nxt[k] = S_FULL;
                            end
                        end
                    end
                end
            end
        end
    end

`ifdef WASTE_BIN_AUTO_EMPTY_EN
    logic [7:0] r_timer [N_CH];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            w_auto[k] = (WRAP == 0) && (r_state[k] == S_FULL) && (r_timer[k] == 8'd1);
        end
    end

    // Timer is (re)loaded whenever the channel enters FULL, including a refill right after an empty.
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int k = 0; k < N_CH; k++) r_timer[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if ((w_state_nxt[k] == S_FULL) && ((r_state[k] != S_FULL) || w_empty[k])) begin
                    r_timer[k] <= 8'(EMPTY_DELAY);
                end else if ((r_state[k] == S_FULL) && (r_timer[k] != 8'd0)) begin
                    r_timer[k] <= r_timer[k] - 8'd1;
                end
            end
        end
    end
`else
    assign w_auto = '0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= S_COUNTING;
                r_count[k] <= '0;
            end
            r_full       <= '0;
            r_wrap       <= '0;
            r_total      <= '0;
            r_drop_err   <= 1'b0;
            r_bad_ch_err <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_count[k] <= w_count_nxt[k];
            end
            r_full <= w_full_nxt;
            r_wrap <= w_wrap_nxt;
            if ((|w_accept) && (r_total != {TOT_W{1'b1}})) begin
                r_total <= r_total + 1'b1;
            end
            if (|w_drop) r_drop_err <= 1'b1;
            if (w_bad_ch) r_bad_ch_err <= 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_count_out
            assign count[g*WIDTH +: WIDTH] = r_count[g];
        end
    endgenerate

    assign full       = r_full;
    assign wrap_pulse = r_wrap;
    assign total      = r_total;
    assign drop_err   = r_drop_err;
    assign bad_ch_err = r_bad_ch_err;

endmodule

// File: tb/tb_waste_bin_counter.sv
// tb/tb_waste_bin_counter.sv - randomized bench for waste_bin_counter against a behavioural bin model
module tb_waste_bin_counter;

    localparam int NI    = 3;
    localparam int DELAY = 4;
`ifdef WASTE_BIN_AUTO_EMPTY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Instance 0: saturating defaults; 1: wrap, LIMIT=3, three channels; 2: 4-bit total.
    int nch    [NI] = '{2, 3, 2};
    int lim    [NI] = '{9, 3, 9};
    int wr     [NI] = '{0, 1, 0};
    int totmax [NI] = '{255, 255, 15};

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic       iv    = 1'b0;
    logic [2:0] ich   = 3'd0;
    logic [7:0] er    = 8'd0;

    always #5 clock = ~clock;

    logic [7:0]  cnt0, tot0, tot1;
    logic [11:0] cnt1;
    logic [7:0]  cnt2;
    logic [3:0]  tot2;
    logic [1:0]  full0, wp0, full2, wp2;
    logic [2:0]  full1, wp1;
    logic        drop0, drop1, drop2, bad0, bad1, bad2;

    waste_bin_counter #(.N_CH(2), .WIDTH(4), .LIMIT(9), .WRAP(0), .TOT_W(8), .EMPTY_DELAY(DELAY)) u_sat (
        .clock(clock), .clear(clear), .item_valid(iv), .item_ch(ich), .empty_req(er[1:0]),
        .count(cnt0), .full(full0), .wrap_pulse(wp0), .total(tot0), .drop_err(drop0), .bad_ch_err(bad0));

    waste_bin_counter #(.N_CH(3), .WIDTH(4), .LIMIT(3), .WRAP(1), .TOT_W(8), .EMPTY_DELAY(DELAY)) u_wrap (
        .clock(clock), .clear(clear), .item_valid(iv), .item_ch(ich), .empty_req(er[2:0]),
        .count(cnt1), .full(full1), .wrap_pulse(wp1), .total(tot1), .drop_err(drop1), .bad_ch_err(bad1));

    waste_bin_counter #(.N_CH(2), .WIDTH(4), .LIMIT(9), .WRAP(0), .TOT_W(4), .EMPTY_DELAY(DELAY)) u_tot (
        .clock(clock), .clear(clear), .item_valid(iv), .item_ch(ich), .empty_req(er[1:0]),
        .count(cnt2), .full(full2), .wrap_pulse(wp2), .total(tot2), .drop_err(drop2), .bad_ch_err(bad2));

    logic [63:0] d_count [NI];
    logic [7:0]  d_full  [NI];
    logic [7:0]  d_wp    [NI];
    logic [7:0]  d_tot   [NI];
    logic        d_drop  [NI];
    logic        d_bad   [NI];

    assign d_count[0] = 64'(cnt0);
    assign d_count[1] = 64'(cnt1);
    assign d_count[2] = 64'(cnt2);
    assign d_full[0] = 8'(full0);
    assign d_full[1] = 8'(full1);
    assign d_full[2] = 8'(full2);
    assign d_wp[0] = 8'(wp0);
    assign d_wp[1] = 8'(wp1);
    assign d_wp[2] = 8'(wp2);
    assign d_tot[0] = tot0;
    assign d_tot[1] = tot1;
    assign d_tot[2] = 8'(tot2);
    assign d_drop[0] = drop0;
    assign d_drop[1] = drop1;
    assign d_drop[2] = drop2;
    assign d_bad[0] = bad0;
    assign d_bad[1] = bad1;
    assign d_bad[2] = bad2;

    // Reference model: plain per-bin item counts and a "bin is full since edge N" record.
    int m_cnt       [NI][8];
    bit m_isfull    [NI][8];
    int m_full_edge [NI][8];
    bit m_fullout   [NI][8];
    bit m_wp        [NI][8];
    int m_tot       [NI];
    bit m_drop      [NI];
    bit m_bad       [NI];
    int edge_no = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    endtask

    task automatic model_step(input int i);
        int acc;
        bit emp, item;
        acc = 0;
        if (clear) begin
            for (int k = 0; k < 8; k++) begin
                m_cnt[i][k] = 0; m_isfull[i][k] = 0; m_fullout[i][k] = 0; m_wp[i][k] = 0;
            end
            m_tot[i] = 0; m_drop[i] = 0; m_bad[i] = 0;
            return;
        end
        if (iv && int'(ich) >= nch[i]) m_bad[i] = 1;
        for (int k = 0; k < nch[i]; k++) begin
            emp  = er[k] || (AUTO && wr[i] == 0 && m_isfull[i][k] && (edge_no - m_full_edge[i][k] == DELAY));
            item = iv && int'(ich) == k;
            m_wp[i][k] = 0;
            m_fullout[i][k] = 0;
            if (emp) begin
                m_cnt[i][k] = 0;
                m_isfull[i][k] = 0;
            end
            if (wr[i] == 0) begin
                if (item) begin
                    if (m_isfull[i][k]) m_drop[i] = 1;
                    else begin
                        m_cnt[i][k]++;
                        acc++;
                        if (m_cnt[i][k] == lim[i]) begin
                            m_isfull[i][k] = 1;
                            m_full_edge[i][k] = edge_no;
                        end
                    end
                end
                m_fullout[i][k] = m_isfull[i][k];
            end else if (item) begin
                acc++;
                if (m_cnt[i][k] == lim[i]) begin
                    m_cnt[i][k] = 0;
                    m_wp[i][k] = 1;
                end else begin
                    m_cnt[i][k]++;
                    if (m_cnt[i][k] == lim[i]) m_fullout[i][k] = 1;
                end
            end
        end
        m_tot[i] = (m_tot[i] + acc > totmax[i]) ? totmax[i] : m_tot[i] + acc;
    endtask

    task automatic compare_all();
        logic [63:0] ec;
        logic [7:0]  ef, ew;
        for (int i = 0; i < NI; i++) begin
            ec = '0; ef = '0; ew = '0;
            for (int k = 0; k < nch[i]; k++) begin
                ec = ec | (64'(m_cnt[i][k]) << (4 * k));
                ef[k] = m_fullout[i][k];
                ew[k] = m_wp[i][k];
            end
            check($sformatf("count[u%0d]", i), d_count[i], ec);
            check($sformatf("full[u%0d]", i), 64'(d_full[i]), 64'(ef));
            check($sformatf("wrap_pulse[u%0d]", i), 64'(d_wp[i]), 64'(ew));
            check($sformatf("total[u%0d]", i), 64'(d_tot[i]), 64'(m_tot[i]));
            check($sformatf("drop_err[u%0d]", i), 64'(d_drop[i]), 64'(m_drop[i]));
            check($sformatf("bad_ch_err[u%0d]", i), 64'(d_bad[i]), 64'(m_bad[i]));
        end
    endtask

    task automatic cycle(input bit c, input bit v, input logic [2:0] ch, input logic [7:0] e);
        clear = c; iv = v; ich = ch; er = e;
        @(posedge clock);
        edge_no++;
        for (int i = 0; i < NI; i++) model_step(i);
        #1;
        compare_all();
    endtask

    initial begin
        logic [7:0] rer;
        // Reset with an item presented, then the first item after release.
        cycle(1, 1, 3'd0, 8'd0);
        cycle(1, 1, 3'd0, 8'd0);
        cycle(0, 1, 3'd0, 8'd0);
        // Fill ch0 past LIMIT.
        cycle(1, 0, 3'd0, 8'd0);
        for (int n = 0; n < 11; n++) cycle(0, 1, 3'd0, 8'd0);
        // Empty/item collision on ch1 at count 5.
        cycle(1, 0, 3'd0, 8'd0);
        for (int n = 0; n < 5; n++) cycle(0, 1, 3'd1, 8'd0);
        cycle(0, 1, 3'd1, 8'b10);
        cycle(0, 0, 3'd0, 8'd0);
        // Bad channel, then enough accepted items to saturate a 4-bit total.
        cycle(0, 1, 3'd5, 8'd0);
        for (int n = 0; n < 20; n++) begin
            cycle(0, 1, 3'(n % 2), 8'd0);
            cycle(0, 0, 3'd0, 8'hff);
        end
        // Fill and wait (auto-empty window), then fill and empty explicitly at the second edge.
        cycle(1, 0, 3'd0, 8'd0);
        for (int n = 0; n < 9; n++) cycle(0, 1, 3'd0, 8'd0);
        for (int n = 0; n < 8; n++) cycle(0, 0, 3'd0, 8'd0);
        for (int n = 0; n < 9; n++) cycle(0, 1, 3'd0, 8'd0);
        cycle(0, 0, 3'd0, 8'd0);
        cycle(0, 0, 3'd0, 8'd1);
        for (int n = 0; n < 8; n++) cycle(0, 0, 3'd0, 8'd0);
        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 8; b++) rer[b] = ($urandom_range(0, 24) == 0);
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 7,
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)),
                  rer);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
